// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the sequential Booth multiplier
package mult_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Booth recoding of {lo[0], q}; 00 and 11 mean pass-through
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_seq_booth_step.sv
// rtl/mult_booth_seq_booth_step.sv - one radix-2 Booth add/sub plus arithmetic shift
module booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [2*WIDTH+1:0] p_i,
   input  logic [WIDTH:0]     m_i,
   output logic [2*WIDTH+1:0] p_o
);

   logic [WIDTH:0]     hi;
   logic [WIDTH:0]     hi_sum;
   logic [2*WIDTH+1:0] p_sum;

   // Add, subtract or pass M into hi, then shift {hi, lo, q} right keeping the sign
   always_comb begin
      hi = p_i[2*WIDTH+1:WIDTH+1];
      case (p_i[1:0])
         BOOTH_ADD: hi_sum = hi + m_i;
         BOOTH_SUB: hi_sum = hi - m_i;
         default:   hi_sum = hi;
      endcase
      p_sum = {hi_sum, p_i[WIDTH:0]};
      p_o   = {p_sum[2*WIDTH+1], p_sum[2*WIDTH+1:1]};
   end

endmodule

// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - sequential signed WIDTHxWIDTH Booth multiplier, low-half result
module mult_booth_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH + 2;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      p_q, p_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;
   logic [PW-1:0]      p_step;
   logic [WIDTH:0]     sign_bits;
   logic               last_step;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .p_i (p_q),
      .m_i (m_q),
      .p_o (p_step)
   );

   // Bits 2W-1..W-1 of the full product; all equal means the low half holds it exactly
   assign sign_bits = p_step[2*WIDTH:WIDTH];
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // Next-state: a start always wins, even over the final step of a running product
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      m_d     = m_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      if (ctrl_MULT) begin
         state_d = RUN;
         cnt_d   = '0;
         m_d     = {data_operandA[WIDTH-1], data_operandA};
         p_d     = {{(WIDTH + 1){1'b0}}, data_operandB, 1'b0};
      end else if (state_q == RUN) begin
         p_d   = p_step;
         cnt_d = cnt_q + 1'b1;
         if (last_step) begin
            state_d = IDLE;
            res_d   = p_step[WIDTH:1];
            exc_d   = ~((&sign_bits) | ~(|sign_bits));
            rdy_d   = 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous active-low clear
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q == RUN);

endmodule
